// File: rtl/program_loader_pkg.sv
// Shared widths, derived sizes and loader state encoding for the program loader.
package program_loader_pkg;

  localparam int N            = 8;                        // byte / data bus width
  localparam int O_SIZE       = 6;                        // opcode width
  localparam int R_SIZE       = 3;                        // GPR address width
  localparam int P_SIZE       = 5;                        // program memory address width
  localparam int I_SIZE       = O_SIZE + 2*R_SIZE + N;    // instruction width
  localparam int LOADER_BYTES = (I_SIZE + N - 1) / N;     // key presses per instruction
  localparam int MEM_DEPTH    = 1 << P_SIZE;              // program RAM depth

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    FULL
  } loaderState_t;

endpackage

// File: rtl/program_loader_if.sv
// Program RAM write port: the loader drives it, the RAM consumes it.
interface program_loader_if;

  logic                                  wrEn;
  logic [program_loader_pkg::P_SIZE-1:0] wrAddr;
  logic [program_loader_pkg::I_SIZE-1:0] wrData;

  modport master (output wrEn, wrAddr, wrData);
  modport slave  (input  wrEn, wrAddr, wrData);

endinterface

// File: rtl/program_loader_edge_detect.sv
// Rising-edge detector for an already-synchronised level.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic keyPrev;

  // Previous level is captured every cycle regardless of who uses the pulse.
  always_ff @(posedge clk) begin
    if (rst) keyPrev <= 1'b0;
    else     keyPrev <= level;
  end

  assign pulse = level & ~keyPrev;

endmodule

// File: rtl/program_loader.sv
// Assembles switch bytes into instructions and writes them sequentially into
// the program RAM from address 0, holding the CPU in reset while loading.
module program_loader
  import program_loader_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                loadReq,
  input  logic                byteKey,
  input  logic [N-1:0]        byteIn,
  program_loader_if.master    wr,
  output logic                cpuHold,
  output logic [1:0]          byteIdx,
  output logic [P_SIZE:0]     progLen
);

  loaderState_t      state, state_nxt;
  logic [P_SIZE:0]   addr, addr_nxt;     // one extra bit so a full memory counts to MEM_DEPTH
  logic [I_SIZE-1:0] asm_q, asm_nxt;
  logic [1:0]        idx_q, idx_nxt;
  logic [P_SIZE:0]   len_q, len_nxt;
  logic              key_rise;

  edge_detect u_key_edge (
    .clk   (clk),
    .rst   (rst),
    .level (byteKey),
    .pulse (key_rise)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and datapath updates; a loadReq fall always beats a key edge.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    asm_nxt   = asm_q;
    idx_nxt   = idx_q;
    len_nxt   = len_q;
    unique case (state)
      IDLE: begin
        if (loadReq) begin
          state_nxt = COLLECT;
          addr_nxt  = '0;
          idx_nxt   = '0;
          asm_nxt   = '0;
        end
      end
      COLLECT: begin
        if (!loadReq) begin
          // Partial instruction is dropped; only completed writes are counted.
          state_nxt = IDLE;
          len_nxt   = addr;
          idx_nxt   = '0;
        end else if (key_rise) begin
          // Shifting out the top keeps only the low bits of the first byte.
          asm_nxt = {asm_q[I_SIZE-N-1:0], byteIn};
          if (idx_q == 2'(LOADER_BYTES-1)) begin
            state_nxt = WRITE;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx_q + 2'd1;
          end
        end
      end
      WRITE: begin
        addr_nxt = addr + 1'b1;
        if (addr == (P_SIZE+1)'(MEM_DEPTH-1)) begin
          state_nxt = FULL;
        end else if (!loadReq) begin
          state_nxt = IDLE;
          len_nxt   = addr + 1'b1;
        end else begin
          state_nxt = COLLECT;
        end
      end
      FULL: begin
        if (!loadReq) begin
          state_nxt = IDLE;
          len_nxt   = addr;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr  <= '0;
      asm_q <= '0;
      idx_q <= '0;
      len_q <= '0;
    end else begin
      addr  <= addr_nxt;
      asm_q <= asm_nxt;
      idx_q <= idx_nxt;
      len_q <= len_nxt;
    end
  end

  // Outputs come straight from registers or a state decode.
  assign wr.wrEn   = (state == WRITE);
  assign wr.wrAddr = addr[P_SIZE-1:0];
  assign wr.wrData = asm_q;
  assign cpuHold   = (state != IDLE);
  assign byteIdx   = idx_q;
  assign progLen   = len_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomised bench for program_loader against a byte-queue model of a load session.
module tb_program_loader;
  import program_loader_pkg::*;

  logic            clk = 1'b0;
  logic            rst, loadReq, byteKey;
  logic [N-1:0]    byteIn;
  logic            cpuHold;
  logic [1:0]      byteIdx;
  logic [P_SIZE:0] progLen;

  program_loader_if wr();

  program_loader dut (
    .clk     (clk),
    .rst     (rst),
    .loadReq (loadReq),
    .byteKey (byteKey),
    .byteIn  (byteIn),
    .wr      (wr),
    .cpuHold (cpuHold),
    .byteIdx (byteIdx),
    .progLen (progLen)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int wr_cycles = 0, exp_writes = 0;

  // Model: bytes pending in the current instruction, instructions written, session active.
  logic [7:0] byte_q[$];
  int         m_count = 0;
  bit         m_active = 0;

  always @(negedge clk) if (wr.wrEn === 1'b1) wr_cycles++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // First byte is most significant; anything above I_SIZE bits falls away.
  function automatic logic [I_SIZE-1:0] exp_instr(input int b0, input int b1, input int b2);
    int v;
    v = b0 * 65536 + b1 * 256 + b2;
    return I_SIZE'(v % (1 << I_SIZE));
  endfunction

  task automatic check_writes(input string tag);
    @(negedge clk); #1;
    chk(tag, 32'(wr_cycles), 32'(exp_writes));
  endtask

  task automatic model_byte(input logic [7:0] b, output bit wexp,
                            output int a, output logic [I_SIZE-1:0] d);
    wexp = 0; a = 0; d = '0;
    if (m_active && m_count < MEM_DEPTH) begin
      byte_q.push_back(b);
      if (byte_q.size() == LOADER_BYTES) begin
        wexp = 1;
        a    = m_count;
        d    = exp_instr(byte_q[0], byte_q[1], byte_q[2]);
        m_count++;
        exp_writes++;
        byte_q.delete();
      end
    end
  endtask

  task automatic enter;
    @(negedge clk); loadReq = 1'b1;
    @(negedge clk);
    chk("hold_on", 32'(cpuHold), 1);
    m_active = 1; m_count = 0; byte_q.delete();
  endtask

  task automatic press(input logic [7:0] b);
    bit wexp; int a; logic [I_SIZE-1:0] d;
    model_byte(b, wexp, a, d);
    @(negedge clk); byteIn = b; byteKey = 1'b1;
    @(negedge clk);
    chk("wr_en", 32'(wr.wrEn), 32'(wexp));
    if (wexp) begin
      chk("wr_addr", 32'(wr.wrAddr), 32'(a));
      chk("wr_data", 32'(wr.wrData), 32'(d));
    end
    byteKey = 1'b0;
    @(negedge clk);
    chk("wr_en_off", 32'(wr.wrEn), 0);
    chk("byte_idx", 32'(byteIdx), 32'(byte_q.size()));
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic drop;
    @(negedge clk); loadReq = 1'b0;
    @(negedge clk);
    m_active = 0; byte_q.delete();
    chk("hold_off", 32'(cpuHold), 0);
    chk("prog_len", 32'(progLen), 32'(m_count));
    chk("idx_after_drop", 32'(byteIdx), 0);
    check_writes("wr_count");
  endtask

  // Final byte of an instruction, with loadReq released during the write cycle.
  task automatic press_drop_in_write(input logic [7:0] b);
    bit wexp; int a; logic [I_SIZE-1:0] d;
    model_byte(b, wexp, a, d);
    @(negedge clk); byteIn = b; byteKey = 1'b1;
    @(negedge clk);
    chk("wr_en_drop", 32'(wr.wrEn), 32'(wexp));
    chk("wr_data_drop", 32'(wr.wrData), 32'(d));
    loadReq = 1'b0; byteKey = 1'b0;
    @(negedge clk);
    m_active = 0; byte_q.delete();
    chk("hold_off_w", 32'(cpuHold), 0);
    chk("prog_len_w", 32'(progLen), 32'(m_count));
    check_writes("wr_count_w");
  endtask

  // loadReq fall and a key edge on the same clock: the fall wins.
  task automatic sim_fall(input logic [7:0] b);
    @(negedge clk); loadReq = 1'b0; byteKey = 1'b1; byteIn = b;
    @(negedge clk);
    m_active = 0; byte_q.delete();
    chk("sim_wr_en", 32'(wr.wrEn), 0);
    chk("sim_hold", 32'(cpuHold), 0);
    chk("sim_len", 32'(progLen), 32'(m_count));
    byteKey = 1'b0;
    check_writes("sim_wr_count");
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_wren"}, 32'(wr.wrEn), 0);
    chk({tag, "_addr"}, 32'(wr.wrAddr), 0);
    chk({tag, "_data"}, 32'(wr.wrData), 0);
    chk({tag, "_hold"}, 32'(cpuHold), 0);
    chk({tag, "_idx"}, 32'(byteIdx), 0);
    chk({tag, "_len"}, 32'(progLen), 0);
  endtask

  initial begin
    rst = 1'b1; loadReq = 1'b0; byteKey = 1'b0; byteIn = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst0");
    rst = 1'b0;

    // Single instruction.
    enter();
    press(8'hA5); press(8'h3C); press(8'h7E);
    drop();

    // One full instruction then a discarded partial one.
    enter();
    press(8'h12); press(8'h34); press(8'h56);
    press(8'h11); press(8'h22);
    drop();

    // Random sessions with random partial tails.
    for (int s = 0; s < 4; s++) begin
      int n, p;
      n = $urandom_range(0, 4);
      p = $urandom_range(0, 2);
      enter();
      for (int i = 0; i < n * LOADER_BYTES + p; i++) press(8'($urandom));
      drop();
    end

    // loadReq released during the write cycle.
    enter();
    press(8'($urandom)); press(8'($urandom));
    press_drop_in_write(8'($urandom));

    // Key held high across entry gives no byte; then a simultaneous fall drops the byte.
    @(negedge clk); byteKey = 1'b1; byteIn = 8'hFF;
    @(negedge clk); loadReq = 1'b1;
    repeat (3) @(negedge clk);
    m_active = 1; m_count = 0; byte_q.delete();
    chk("held_idx", 32'(byteIdx), 0);
    chk("held_hold", 32'(cpuHold), 1);
    byteKey = 1'b0;
    press(8'h01); press(8'h02);
    sim_fall(8'h03);

    // Fill the memory, then extra presses in FULL are ignored.
    enter();
    for (int i = 0; i < MEM_DEPTH * LOADER_BYTES; i++) press(8'($urandom));
    press(8'h55); press(8'hAA);
    chk("full_hold", 32'(cpuHold), 1);
    drop();

    // Reset in the middle of the second instruction.
    enter();
    for (int i = 0; i < LOADER_BYTES + 2; i++) press(8'($urandom));
    @(negedge clk); rst = 1'b1; loadReq = 1'b0;
    @(negedge clk);
    check_reset_vals("rst_mid");
    rst = 1'b0;
    m_active = 0; m_count = 0; byte_q.delete();
    press(8'h77); press(8'h88); press(8'h99);
    check_writes("rst_no_wr");

    // Re-load starts again at address 0.
    enter();
    for (int i = 0; i < 2 * LOADER_BYTES; i++) press(8'($urandom));
    drop();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
